alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Issue/retire front end for the ALU: accepts one instruction at a time from fetch and decodes its register/immediate fields.
- Reads the integer register file (owned by this block) and drives instr/op1/op2/enable into the ALU.
- Samples the ALU's instr_exec/result and writes the result back to rd.
- Sits between the fetch stage and the ALU; it is the producer of ALU inputs and the consumer of ALU outputs.

Parameters:
- trace, 0, when 1 (non-synthesis only) print $display with $time, pc and decode_instr(instr) at each retire.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  fetch presents an instruction
- instr  input  instruction_t  instruction word (RV32I encoding)
- pc  input  register_t  address of instr
- instr_ready  output  1  sequencer accepts instr this cycle
- alu_instr  output  instruction_t  to ALU instr
- alu_op1  output  register_t  to ALU op1
- alu_op2  output  register_t  to ALU op2
- alu_enable  output  1  to ALU enable
- alu_instr_exec  input  1  from ALU instr_exec
- alu_result  input  register_t  from ALU result
- retire_valid  output  1  one-cycle pulse: instruction completed
- retire_rd  output  5  destination register of the retired instruction
- retire_data  output  register_t  ALU result of the retired instruction
- illegal  output  1  one-cycle pulse: ALU rejected the instruction
- dbg_addr  input  5  debug register-file read address
- dbg_data  output  register_t  combinational read of reg[dbg_addr]; 0 when dbg_addr=0

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all 31 registers x1..x31 = 0.
  - alu_enable, retire_valid, illegal = 0; retire_rd, retire_data, alu_instr, alu_op1, alu_op2 = 0.
  - Reset during any state aborts the instruction: no write-back and no retire pulse.
- Register file: 32 x register_t; x0 reads 0; writes to x0 are discarded.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: instr_ready=1. On instr_valid, latch instr and pc, and latch operands from the register file as of this cycle, then go to ISSUE.
  - ISSUE: alu_enable=1 for exactly one cycle with registered alu_instr/op1/op2; go to WAIT.
  - WAIT: alu_enable=0; sample alu_instr_exec/alu_result (the ALU registers them on the ISSUE edge).
    - If alu_instr_exec=1: write alu_result to rd at the end of this cycle.
    - Next cycle: retire_valid=1, retire_rd=rd, retire_data=alu_result.
    - If alu_instr_exec=0: no write; next cycle illegal=1 and retire_valid=0.
    - Go to IDLE.
- Latency: accept in cycle N; alu_enable in N+1; write-back at the N+2 edge; retire/illegal pulse and register visible via dbg_data in N+3. instr_ready re-asserts in N+3, giving a throughput of 1 instruction per 3 cycles. No hazards, because execution is strictly serial.
- Operand selection, by opcode instr[6:0]:
  - 0110011 (R): op1=rs1, op2=rs2.
  - 0010011 (I): op1=rs1, op2=sign-extended instr[31:20]. Shifts pass the same value; the ALU uses op2[4:0].
  - 0110111 (LUI): op1={instr[31:12],12'b0}, op2=0.
  - 0010111 (AUIPC): op1={instr[31:12],12'b0}, op2=pc.
  - Any other opcode: op1=rs1, op2=rs2. Legality is decided solely by the ALU's alu_instr_exec.
- Outputs alu_op1/alu_op2/alu_instr hold their values outside ISSUE.
- retire_rd/retire_data hold their values between pulses.
- A retire with rd=0 still pulses retire_valid with the ALU result; the register file is unchanged.
- Read-after-write: the next instruction accepted in N+3 reads the value written at the N+2 edge.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_HALT_EN.
- Defined: on the first illegal response, the illegal pulse fires as usual, then the FSM enters HALT. In HALT, instr_ready=0 permanently and no further ALU enables are issued, until rst.
- Undefined: illegal instructions are dropped and the FSM returns to IDLE (normal 3-cycle cadence).

Test Plan:
- Reset, then dbg_addr 0..31 -> all dbg_data=0; instr_ready=1 in the first post-reset cycle.
- ADDI x1,x0,5 then ADDI x2,x1,-7 -> retire_data 5 then 0xFFFFFFFE; dbg x2=0xFFFFFFFE; alu_enable high exactly 1 cycle per instruction; 3-cycle spacing between retire pulses.
- LUI x3,0x12345 then AUIPC x4,0x1 with pc=0x100 -> x3=0x12345000, x4=0x00001100.
- ADD x0,x1,x1 with x1=5 -> retire_valid=1, retire_rd=0, retire_data=10; dbg x0=0.
- Opcode 0x7F (ALU returns instr_exec=0) -> illegal pulse, no retire, no register change. Without the macro, the next ADDI retires normally; with ALU_SEQ_ILLEGAL_HALT_EN, instr_ready stays 0 until rst.
- Assert rst during WAIT of ADDI x5,x0,9 -> no retire pulse, x5=0, state IDLE and instr_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_sequencer.sv
// Serial issue/retire front end for the ALU: decodes one RV32I instruction at a time,
// reads and writes the register file, and retires the result. Optional: ALU_SEQ_ILLEGAL_HALT_EN.
package alu_seq_pkg;
  typedef logic [31:0] instruction_t;
  typedef logic [31:0] register_t;
endpackage

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit trace = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  instruction_t instr,
  input  register_t    pc,
  output logic         instr_ready,
  output instruction_t alu_instr,
  output register_t    alu_op1,
  output register_t    alu_op2,
  output logic         alu_enable,
  input  logic         alu_instr_exec,
  input  register_t    alu_result,
  output logic         retire_valid,
  output logic [4:0]   retire_rd,
  output register_t    retire_data,
  output logic         illegal,
  input  logic [4:0]   dbg_addr,
  output register_t    dbg_data
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t    state;
  register_t regs [1:31];
  register_t pc_p0;
  register_t rs1_val, rs2_val;
  register_t op1_sel, op2_sel;
  logic [4:0] wb_rd;

  function automatic register_t sext12(input logic signed [11:0] v);
    logic signed [31:0] t;
    t = v;
    return register_t'(t);
  endfunction

  function automatic register_t upper_imm(input instruction_t i);
    return {i[31:12], 12'b0};
  endfunction

  // Register-file reads are combinational so operands reflect writes from the previous edge.
  always_comb begin
    rs1_val  = (instr[19:15] == 5'd0) ? '0 : regs[instr[19:15]];
    rs2_val  = (instr[24:20] == 5'd0) ? '0 : regs[instr[24:20]];
    dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
    op1_sel  = rs1_val;
    op2_sel  = rs2_val;
    case (instr[6:0])
      OP_R: begin
        op1_sel = rs1_val;
        op2_sel = rs2_val;
      end
      OP_I: begin
        op1_sel = rs1_val;
        op2_sel = sext12(instr[31:20]);
      end
      OP_LUI: begin
        op1_sel = upper_imm(instr);
        op2_sel = '0;
      end
      OP_AUIPC: begin
        op1_sel = upper_imm(instr);
        op2_sel = pc;
      end
      default: begin
        op1_sel = rs1_val;
        op2_sel = rs2_val;
      end
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign wb_rd       = alu_instr[11:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      alu_enable   <= 1'b0;
      retire_valid <= 1'b0;
      illegal      <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      alu_instr    <= '0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      retire_valid <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        // accept: capture instruction and operands
        IDLE: begin
          if (instr_valid) begin
            alu_instr  <= instr;
            alu_op1    <= op1_sel;
            alu_op2    <= op2_sel;
            pc_p0      <= pc;
            alu_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        // issue: ALU registers its response on this edge
        ISSUE: begin
          alu_enable <= 1'b0;
          state      <= WAIT;
        end
        // write-back and retire
        WAIT: begin
          if (alu_instr_exec) begin
            if (wb_rd != 5'd0) regs[wb_rd] <= alu_result;
            retire_valid <= 1'b1;
            retire_rd    <= wb_rd;
            retire_data  <= alu_result;
            state        <= IDLE;
          end else begin
            illegal <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_HALT_EN
            state   <= HALT;
`else
            state   <= IDLE;
`endif
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  function automatic string decode_instr(input instruction_t i);
    string m;
    case (i[6:0])
      OP_R:     m = "OP";
      OP_I:     m = "OP-IMM";
      OP_LUI:   m = "LUI";
      OP_AUIPC: m = "AUIPC";
      default:  m = "UNKNOWN";
    endcase
    return $sformatf("%s rd=x%0d rs1=x%0d rs2=x%0d f3=%0d", m, i[11:7], i[19:15], i[24:20], i[14:12]);
  endfunction

  always_ff @(posedge clk) begin
    if (trace && retire_valid)
      $display("%0t pc=%08h %s", $time, pc_p0, decode_instr(alu_instr));
  end
`endif

endmodule
